pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the program counter and drives the synchronous instruction-ROM address.
- Supplies the sequential next-PC value that decode latches alongside the instruction word.
- Handles start-up, CPU enable/halt, stall, and branch/jump redirection.

Parameters:
ADR_BIT, 16, width of PC / ROM word address (matches `ADR_BIT)
RESET_PC, 16'h0000, PC value loaded on reset
CNT_BIT, 32, width of the fetch performance counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
enable_CPU  input  1  run enable; low = halt fetch, hold PC
ena_n  input  1  active-low fetch enable (same signal decode uses); high = stall, hold PC
branch_taken  input  1  redirect request from execute; same signal that flushes decode
branch_target  input  ADR_BIT  redirect address, valid with branch_taken
jump  input  1  unconditional jump request from decode
jump_target  input  ADR_BIT  jump address, valid with jump
ROM_addr  output  ADR_BIT  word address to instruction ROM (= pc register)
pc_next_inw  output  ADR_BIT  pc + 1 (mod 2^ADR_BIT), combinational from pc register
fetch_valid  output  1  registered; high when ROM_addr is a real fetch this cycle
state  output  2  current FSM state, for debug
fetch_cnt  output  CNT_BIT  number of accepted fetches since reset

Behaviour:
- Reset (rst=1 at an edge): pc<=RESET_PC; state<=S_BOOT; fetch_valid<=0; fetch_cnt<=0.
- Reset has priority over every other input, including mid-redirect and mid-stall.
- Addressing: ROM_addr = pc. pc_next_inw = pc+1, truncated to ADR_BIT, so 16'hFFFF -> 16'h0000.
- ROM read latency is 1 cycle. Decode samples the ROM data and pc_next_inw on the same edge.
- FSM states (encoding 2'd0/1/2): S_BOOT, S_IDLE, S_RUN.
- S_BOOT: lasts exactly 1 cycle with fetch_valid=0. Next state is S_RUN if enable_CPU=1, else S_IDLE.
- S_IDLE:
  - pc holds; fetch_valid=0.
  - enable_CPU=1 -> S_RUN next cycle, fetching the held pc.
- S_RUN:
  - enable_CPU=0 -> S_IDLE; pc holds, no increment.
- PC update in S_RUN/S_IDLE, priority order:
  1. branch_taken -> pc<=branch_target.
  2. jump -> pc<=jump_target.
  3. ena_n=1 -> hold.
  4. state==S_RUN and enable_CPU=1 -> pc<=pc+1 (wraps).
  5. Otherwise hold.
- Redirect rules:
  - A redirect is honoured in S_IDLE; PC is loaded and the state stays S_IDLE.
  - A redirect is ignored in S_BOOT.
  - Redirect beats stall: branch_taken with ena_n=1 still loads branch_target.
  - branch_taken and jump together: branch wins, jump dropped.
- fetch_valid:
  - Registered; next value = (next state is S_RUN).
  - Forced to 0 for one cycle after any redirect (bubble; decode is being flushed that cycle).
- fetch_cnt:
  - Increments by 1 on each edge where state==S_RUN, enable_CPU=1, ena_n=0, and no redirect.
  - Wraps at 2^CNT_BIT.
- Timing: branch_taken sampled at edge t means ROM_addr=branch_target and pc_next_inw=branch_target+1 during cycle t+1.
- No combinational path from any input to ROM_addr. pc_next_inw depends only on the pc register.

Decomposition:
- Add to global_macro.v:
  - `PC_ST_BOOT, `PC_ST_IDLE, `PC_ST_RUN (2-bit state encodings).
  - `RESET_PC default.
  - Reuse existing `ADR_BIT.
- No sub-module needed. The incrementer and next-PC priority mux are plain logic inside pc_fetch.
- Estimated RTL size: about 150 lines.

Test Plan:
- Reset, enable_CPU=1, ena_n=0 for 5 cycles -> ROM_addr 0 (BOOT, fetch_valid=0), then 0,1,2,3; pc_next_inw = ROM_addr+1; fetch_cnt=4 after the fourth RUN fetch.
- At ROM_addr=5, drive branch_taken=1, branch_target=16'h0040 for 1 cycle -> next cycle ROM_addr=16'h0040, pc_next_inw=16'h0041, fetch_valid=0; the following cycle ROM_addr=16'h0041, fetch_valid=1.
- ena_n=1 for 3 cycles at ROM_addr=16'h0010 -> ROM_addr holds 16'h0010, fetch_cnt unchanged; ena_n=0 -> 16'h0011 next cycle.
- branch_taken=1 (target 16'h0100) and jump=1 (target 16'h0200) in the same cycle, with ena_n=1 -> ROM_addr=16'h0100.
- Force pc=16'hFFFE, run -> ROM_addr 16'hFFFE, 16'hFFFF, 16'h0000; pc_next_inw=16'h0000 while ROM_addr=16'hFFFF.
- enable_CPU=0 at ROM_addr=7 -> state=S_IDLE, ROM_addr held at 7, fetch_valid=0; then assert rst while idle mid-stall -> ROM_addr=0, state=S_BOOT, fetch_cnt=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   pc_state_e       : fetch FSM state encoding (BOOT=0, IDLE=1, RUN=2)
//   PC_ADR_BIT       : default PC / ROM word-address width
//   PC_RESET_DEFAULT : default PC value loaded on reset
package pc_fetch_pkg;

  localparam int unsigned PC_ADR_BIT = 16;
  localparam logic [PC_ADR_BIT-1:0] PC_RESET_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the program counter and drives the
// synchronous instruction-ROM address.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable_CPU      : run enable (low = halt, hold PC)
//   ena_n           : active-low fetch enable (high = stall, hold PC)
//   branch_taken/
//   branch_target   : redirect from execute (highest priority)
//   jump/jump_target: unconditional jump from decode
//   ROM_addr        : ROM word address (= pc register)
//   pc_next_inw     : pc + 1, from the pc register only
//   fetch_valid     : registered, high when ROM_addr is a real fetch
//   state           : current FSM state (debug)
//   fetch_cnt       : accepted fetches since reset
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned           ADR_BIT  = PC_ADR_BIT,
  parameter logic [ADR_BIT-1:0]    RESET_PC = PC_RESET_DEFAULT,
  parameter int unsigned           CNT_BIT  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_CPU,
  input  logic               ena_n,
  input  logic               branch_taken,
  input  logic [ADR_BIT-1:0] branch_target,
  input  logic               jump,
  input  logic [ADR_BIT-1:0] jump_target,
  output logic [ADR_BIT-1:0] ROM_addr,
  output logic [ADR_BIT-1:0] pc_next_inw,
  output logic               fetch_valid,
  output logic [1:0]         state,
  output logic [CNT_BIT-1:0] fetch_cnt
);

  pc_state_e          state_q, state_d;
  logic [ADR_BIT-1:0] pc_q, pc_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [CNT_BIT-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [ADR_BIT-1:0] pc_inc;
  logic               redirect;

  assign pc_inc = pc_q + ADR_BIT'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    // Redirects are only honoured once out of BOOT.
    redirect    = (state_q != S_BOOT) && (branch_taken || jump);

    unique case (state_q)
      S_BOOT: state_d = enable_CPU ? S_RUN : S_IDLE;
      S_IDLE: if (enable_CPU && !redirect) state_d = S_RUN;
      S_RUN:  if (!enable_CPU) state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase

    if (state_q == S_IDLE || state_q == S_RUN) begin
      if (branch_taken)                          pc_d = branch_target;
      else if (jump)                             pc_d = jump_target;
      else if (ena_n)                            pc_d = pc_q;
      else if (state_q == S_RUN && enable_CPU)   pc_d = pc_inc;
    end

    if (state_q == S_RUN && enable_CPU && !ena_n && !redirect)
      fetch_cnt_d = fetch_cnt_q + CNT_BIT'(1);

    // Bubble the cycle after a redirect while decode is being flushed.
    fetch_valid_d = (state_d == S_RUN) && !redirect;
  end

  assign ROM_addr    = pc_q;
  assign pc_next_inw = pc_inc;
  assign fetch_valid = fetch_valid_q;
  assign state       = state_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_CPU;
  logic        ena_n;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] ROM_addr;
  logic [15:0] pc_next_inw;
  logic        fetch_valid;
  logic [1:0]  state;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch #(.ADR_BIT(16), .RESET_PC(16'h0000), .CNT_BIT(32)) dut (
    .clk(clk), .rst(rst), .enable_CPU(enable_CPU), .ena_n(ena_n),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .ROM_addr(ROM_addr), .pc_next_inw(pc_next_inw),
    .fetch_valid(fetch_valid), .state(state), .fetch_cnt(fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_CPU = 1'b1; ena_n = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (ROM_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", ROM_addr); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", fetch_valid); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_sequential();
    step();  // BOOT -> RUN, pc held
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL seq_state got %0d want 2", state); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv got %b want 1", fetch_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ROM_addr !== 16'(i)) begin errors++; $display("FAIL seq_addr%0d got %h want %h", i, ROM_addr, 16'(i)); end
      checks++; if (pc_next_inw !== 16'(i + 1)) begin errors++; $display("FAIL seq_next%0d got %h want %h", i, pc_next_inw, 16'(i + 1)); end
      checks++; if (fetch_cnt !== 32'(i)) begin errors++; $display("FAIL seq_cnt%0d got %0d want %0d", i, fetch_cnt, i); end
      if (i < 4) step();
    end
  endtask

  task automatic test_branch();
    step();  // ROM_addr 5, cnt 5
    checks++; if (ROM_addr !== 16'h0005) begin errors++; $display("FAIL br_pre got %h want 0005", ROM_addr); end
    branch_taken = 1'b1; branch_target = 16'h0040;
    step();
    branch_taken = 1'b0;
    checks++; if (ROM_addr !== 16'h0040) begin errors++; $display("FAIL br_addr got %h want 0040", ROM_addr); end
    checks++; if (pc_next_inw !== 16'h0041) begin errors++; $display("FAIL br_next got %h want 0041", pc_next_inw); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got %b want 0", fetch_valid); end
    checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL br_cnt got %0d want 5", fetch_cnt); end
    step();
    checks++; if (ROM_addr !== 16'h0041) begin errors++; $display("FAIL br_addr2 got %h want 0041", ROM_addr); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL br_fv2 got %b want 1", fetch_valid); end
    checks++; if (fetch_cnt !== 32'd6) begin errors++; $display("FAIL br_cnt2 got %0d want 6", fetch_cnt); end
  endtask

  task automatic test_stall();
    jump = 1'b1; jump_target = 16'h0010;
    step();
    jump = 1'b0;
    checks++; if (ROM_addr !== 16'h0010) begin errors++; $display("FAIL jmp_addr got %h want 0010", ROM_addr); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble got %b want 0", fetch_valid); end
    ena_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ROM_addr !== 16'h0010) begin errors++; $display("FAIL stall_addr%0d got %h want 0010", i, ROM_addr); end
      checks++; if (fetch_cnt !== 32'd6) begin errors++; $display("FAIL stall_cnt%0d got %0d want 6", i, fetch_cnt); end
    end
    ena_n = 1'b0;
    step();
    checks++; if (ROM_addr !== 16'h0011) begin errors++; $display("FAIL unstall_addr got %h want 0011", ROM_addr); end
    checks++; if (fetch_cnt !== 32'd7) begin errors++; $display("FAIL unstall_cnt got %0d want 7", fetch_cnt); end
  endtask

  task automatic test_branch_jump();
    branch_taken = 1'b1; branch_target = 16'h0100;
    jump = 1'b1; jump_target = 16'h0200; ena_n = 1'b1;
    step();
    branch_taken = 1'b0; jump = 1'b0; ena_n = 1'b0;
    checks++; if (ROM_addr !== 16'h0100) begin errors++; $display("FAIL brjmp_addr got %h want 0100", ROM_addr); end
    checks++; if (fetch_cnt !== 32'd7) begin errors++; $display("FAIL brjmp_cnt got %0d want 7", fetch_cnt); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 16'hFFFE;
    step();
    jump = 1'b0;
    checks++; if (ROM_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_a got %h want FFFE", ROM_addr); end
    step();
    checks++; if (ROM_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_b got %h want FFFF", ROM_addr); end
    checks++; if (pc_next_inw !== 16'h0000) begin errors++; $display("FAIL wrap_next got %h want 0000", pc_next_inw); end
    step();
    checks++; if (ROM_addr !== 16'h0000) begin errors++; $display("FAIL wrap_c got %h want 0000", ROM_addr); end
    checks++; if (pc_next_inw !== 16'h0001) begin errors++; $display("FAIL wrap_next2 got %h want 0001", pc_next_inw); end
  endtask

  task automatic test_idle_reset();
    jump = 1'b1; jump_target = 16'h0007;
    step();
    jump = 1'b0; enable_CPU = 1'b0;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL idle_state got %0d want 1", state); end
    checks++; if (ROM_addr !== 16'h0007) begin errors++; $display("FAIL idle_addr got %h want 0007", ROM_addr); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL idle_fv got %b want 0", fetch_valid); end
    step();
    checks++; if (ROM_addr !== 16'h0007) begin errors++; $display("FAIL idle_hold got %h want 0007", ROM_addr); end
    branch_taken = 1'b1; branch_target = 16'h0030;
    step();
    branch_taken = 1'b0;
    checks++; if (ROM_addr !== 16'h0030) begin errors++; $display("FAIL idle_br got %h want 0030", ROM_addr); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL idle_br_state got %0d want 1", state); end
    enable_CPU = 1'b1;
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL resume_state got %0d want 2", state); end
    checks++; if (ROM_addr !== 16'h0030) begin errors++; $display("FAIL resume_addr got %h want 0030", ROM_addr); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL resume_fv got %b want 1", fetch_valid); end
    enable_CPU = 1'b0; ena_n = 1'b1;
    step();
    checks++; if (ROM_addr !== 16'h0030) begin errors++; $display("FAIL halt_addr got %h want 0030", ROM_addr); end
    rst = 1'b1; branch_taken = 1'b1; branch_target = 16'h0055;
    step();
    rst = 1'b0; branch_taken = 1'b0;
    checks++; if (ROM_addr !== 16'h0000) begin errors++; $display("FAIL rst2_addr got %h want 0000", ROM_addr); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst2_state got %0d want 0", state); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst2_cnt got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_boot_ignores_redirect();
    enable_CPU = 1'b1; ena_n = 1'b0;
    branch_taken = 1'b1; branch_target = 16'h0099;
    step();
    branch_taken = 1'b0;
    checks++; if (ROM_addr !== 16'h0000) begin errors++; $display("FAIL boot_br_addr got %h want 0000", ROM_addr); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL boot_br_state got %0d want 2", state); end
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL boot_br_fv got %b want 1", fetch_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_branch_jump();
    test_wrap();
    test_idle_reset();
    test_boot_ignores_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
